// File: rtl/rggen_register_access_sequencer_if.sv
// CSR bus between a requester and the register access sequencer.
// One request and one response channel, each with a valid/ready handshake.
interface rggen_register_access_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [1:0]               resp_status;
  logic [BUS_WIDTH-1:0]     resp_read_data;

  modport master (
    output req_valid, address, write, write_data, strobe, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_read_data
  );

  modport slave (
    input  req_valid, address, write, write_data, strobe, resp_ready,
    output req_ready, resp_valid, resp_status, resp_read_data
  );
endinterface

// File: rtl/rggen_register_access_sequencer.sv
// CSR request decoder and access sequencer feeding the bit-field instances.
// Optional ACCESS timeout enabled with `define RGGEN_ACCESS_TIMEOUT_EN.
module rggen_register_access_sequencer #(
  parameter int                             ADDRESS_WIDTH     = 8,
  parameter int                             BUS_WIDTH         = 32,
  parameter int                             REGISTERS         = 4,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0] REGISTER_ADDRESS =
    {REGISTERS*ADDRESS_WIDTH{1'b0}},
  parameter logic                           ERROR_STATUS      = 1'b1,
  parameter logic [BUS_WIDTH-1:0]           DEFAULT_READ_DATA = {BUS_WIDTH{1'b0}},
  parameter int                             TIMEOUT_CYCLES    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rggen_register_access_sequencer_if.slave bus,
  output logic [REGISTERS-1:0]           register_select,
  output logic                           sw_write_valid,
  output logic                           sw_read_valid,
  output logic [BUS_WIDTH-1:0]           sw_mask,
  output logic [BUS_WIDTH-1:0]           sw_write_data,
  input  logic [REGISTERS-1:0]           register_ready,
  input  logic [REGISTERS*BUS_WIDTH-1:0] register_read_data
);
  localparam int LSB = $clog2(BUS_WIDTH/8);
  localparam int AW  = ADDRESS_WIDTH - LSB;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } state_t;

  state_t               state;
  logic                 write_q;
  logic [REGISTERS-1:0] select_next;
  logic                 found;
  logic [BUS_WIDTH-1:0] mask_next;
  logic [BUS_WIDTH-1:0] selected;
  logic                 hit;
  logic                 done;

  generate
    if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^bus.address[LSB-1:0];
    end
  endgenerate

  // Word-granular decode; the lowest matching index wins.
  always_comb begin
    select_next = '0;
    found = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (!found &&
          bus.address[ADDRESS_WIDTH-1:LSB] ==
          REGISTER_ADDRESS[i*ADDRESS_WIDTH+LSB +: AW]) begin
        select_next[i] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    mask_next = '0;
    for (int b = 0; b < BUS_WIDTH/8; b++) begin
      mask_next[8*b +: 8] = {8{bus.strobe[b]}};
    end
  end

  always_comb begin
    selected = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (register_select[i]) begin
        selected |= register_read_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  assign hit  = |register_select;
  assign done = !hit || |(register_ready & register_select);

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      write_q             <= 1'b0;
      bus.req_ready       <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_status     <= 2'b00;
      bus.resp_read_data  <= '0;
      register_select     <= '0;
      sw_write_valid      <= 1'b0;
      sw_read_valid       <= 1'b0;
      sw_mask             <= '0;
      sw_write_data       <= '0;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
      count               <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state           <= ACCESS;
            bus.req_ready   <= 1'b0;
            write_q         <= bus.write;
            register_select <= select_next;
            sw_write_valid  <= found && bus.write;
            sw_read_valid   <= found && !bus.write;
            sw_mask         <= bus.write ? mask_next : '1;
            sw_write_data   <= bus.write_data;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
            count           <= '0;
`endif
          end
        end
        ACCESS: begin
          if (done) begin
            state              <= RESPONSE;
            bus.resp_valid     <= 1'b1;
            register_select    <= '0;
            sw_write_valid     <= 1'b0;
            sw_read_valid      <= 1'b0;
            bus.resp_status    <= (!hit && ERROR_STATUS) ? 2'b10 : 2'b00;
            bus.resp_read_data <= write_q ? '0 :
                                  hit     ? selected : DEFAULT_READ_DATA;
          end
`ifdef RGGEN_ACCESS_TIMEOUT_EN
          else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
            state              <= RESPONSE;
            bus.resp_valid     <= 1'b1;
            register_select    <= '0;
            sw_write_valid     <= 1'b0;
            sw_read_valid      <= 1'b0;
            bus.resp_status    <= 2'b11;
            bus.resp_read_data <= '0;
          end else begin
            count <= count + 1'b1;
          end
`endif
        end
        RESPONSE: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// Randomised bench for the register access sequencer.
// Two instances: error status on misses, and OKAY with default data 1.
module tb_rggen_register_access_sequencer;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   register_ready = '1;
  logic [127:0] register_read_data = '0;
  logic [3:0]   sel, sel0;
  logic         wv, rv, wv0, rv0;
  logic [31:0]  mask, wdata, mask0, wdata0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] map [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};

  rggen_register_access_sequencer_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) b();
  rggen_register_access_sequencer_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) b0();

  assign b0.req_valid  = b.req_valid;
  assign b0.address    = b.address;
  assign b0.write      = b.write;
  assign b0.write_data = b.write_data;
  assign b0.strobe     = b.strobe;
  assign b0.resp_ready = b.resp_ready;

  rggen_register_access_sequencer #(
    .REGISTER_ADDRESS ({8'h0C, 8'h08, 8'h04, 8'h00}),
    .ERROR_STATUS     (1'b1),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (b),
    .register_select    (sel),
    .sw_write_valid     (wv),
    .sw_read_valid      (rv),
    .sw_mask            (mask),
    .sw_write_data      (wdata),
    .register_ready     (register_ready),
    .register_read_data (register_read_data)
  );

  rggen_register_access_sequencer #(
    .REGISTER_ADDRESS  ({8'h0C, 8'h08, 8'h04, 8'h00}),
    .ERROR_STATUS      (1'b0),
    .DEFAULT_READ_DATA (32'h0000_0001),
    .TIMEOUT_CYCLES    (TO)
  ) dut0 (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (b0),
    .register_select    (sel0),
    .sw_write_valid     (wv0),
    .sw_read_valid      (rv0),
    .sw_mask            (mask0),
    .sw_write_data      (wdata0),
    .register_ready     (register_ready),
    .register_read_data (register_read_data)
  );

  always #5 clk = ~clk;

  task automatic do_txn(
    input logic [7:0]  addr,
    input logic        write,
    input logic [31:0] wd,
    input logic [3:0]  strb,
    input int          delay,
    input int          hold,
    input logic        use_fix,
    input logic [31:0] rd_fix,
    input string       tag
  );
    int          idx;
    logic        hit, tmo, got;
    logic [3:0]  e_sel;
    logic [31:0] e_mask, e_data, e0_data;
    logic [1:0]  e_st, e0_st;
    logic [31:0] rd [4];
    int          e_acc, acc;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (idx < 0 && addr[7:2] == map[i][7:2]) idx = i;
    hit = (idx >= 0);
    e_sel = hit ? 4'(1 << idx) : 4'b0;
    for (int i = 0; i < 4; i++) begin
      rd[i] = $urandom;
      e_mask[8*i +: 8] = write ? {8{strb[i]}} : 8'hFF;
    end
    if (use_fix && hit) rd[idx] = rd_fix;
    tmo = 1'b0;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
    tmo = hit && delay >= TO;
`endif
    e_acc = !hit ? 1 : tmo ? TO : delay + 1;
    e_st = tmo ? 2'b11 : !hit ? 2'b10 : 2'b00;
    e0_st = tmo ? 2'b11 : 2'b00;
    e_data = (write || tmo || !hit) ? 32'h0 : rd[idx];
    e0_data = (!hit && !write) ? 32'h1 : e_data;

    @(posedge clk); #1;
    register_read_data = {rd[3], rd[2], rd[1], rd[0]};
    register_ready = (delay == 0) ? 4'hF : 4'h0;
    b.req_valid = 1'b1;
    b.address = addr;
    b.write = write;
    b.write_data = wd;
    b.strobe = strb;
    @(negedge clk);
    n_vec++;
    if (b.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_ready idle: got %b want 1", tag, b.req_ready);
    end
    acc = 0;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        b.req_valid = 1'b0;
        b.address = 8'($urandom);
        b.write = 1'($urandom);
        b.write_data = $urandom;
        b.strobe = 4'($urandom);
      end
      if (acc == delay) register_ready = 4'hF;
      @(negedge clk);
      if (b.resp_valid) begin
        got = 1'b1;
        break;
      end
      n_vec++;
      if ({b.req_ready, sel, wv, rv, sel0, wv0, rv0} !==
          {1'b0, e_sel, hit && write, hit && !write,
           e_sel, hit && write, hit && !write}) begin
        n_err++;
        $display("FAIL %s access: rdy/sel/wv/rv got %b %b %b %b want 0 %b %b %b",
                 tag, b.req_ready, sel, wv, rv, e_sel, hit && write, hit && !write);
      end
      if (hit) begin
        n_vec++;
        if ({mask, wdata} !== {e_mask, wd}) begin
          n_err++;
          $display("FAIL %s mask/wdata: got %h %h want %h %h",
                   tag, mask, wdata, e_mask, wd);
        end
      end
      acc++;
    end
    register_ready = 4'hF;
    n_vec++;
    if (!got || acc != e_acc) begin
      n_err++;
      $display("FAIL %s access cycles: got %0d (resp %b) want %0d",
               tag, acc, got, e_acc);
    end
    if (!got) return;
    n_vec++;
    if ({b.resp_status, b.resp_read_data, b.req_ready, sel, wv, rv} !==
        {e_st, e_data, 1'b0, 4'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s resp: st %b data %h rdy %b sel %b wv %b rv %b want %b %h 0 0 0 0",
               tag, b.resp_status, b.resp_read_data, b.req_ready, sel, wv, rv,
               e_st, e_data);
    end
    n_vec++;
    if ({b0.resp_valid, b0.resp_status, b0.resp_read_data} !==
        {1'b1, e0_st, e0_data}) begin
      n_err++;
      $display("FAIL %s resp okay-variant: v %b st %b data %h want 1 %b %h",
               tag, b0.resp_valid, b0.resp_status, b0.resp_read_data, e0_st, e0_data);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      register_read_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_vec++;
      if ({b.resp_valid, b.resp_status, b.resp_read_data, b.req_ready} !==
          {1'b1, e_st, e_data, 1'b0}) begin
        n_err++;
        $display("FAIL %s hold %0d: v %b st %b data %h rdy %b want 1 %b %h 0",
                 tag, h, b.resp_valid, b.resp_status, b.resp_read_data,
                 b.req_ready, e_st, e_data);
      end
    end
    b.resp_ready = 1'b1;
    @(posedge clk); #1;
    b.resp_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({b.resp_valid, b.req_ready, b0.resp_valid, b0.req_ready} !== 4'b0101) begin
      n_err++;
      $display("FAIL %s release: v %b rdy %b v0 %b rdy0 %b want 0 1 0 1",
               tag, b.resp_valid, b.req_ready, b0.resp_valid, b0.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({b.req_ready, b.resp_valid, b.resp_status, b.resp_read_data,
         sel, wv, rv, mask, wdata} !== {1'b1, 1'b0, 2'b00, 32'h0,
         4'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset: rdy %b v %b st %b data %h sel %b wv %b rv %b mask %h wd %h",
               b.req_ready, b.resp_valid, b.resp_status, b.resp_read_data,
               sel, wv, rv, mask, wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    do_txn(8'h04, 1'b1, 32'hA5A5_1234, 4'b0011, 0, 0, 1'b0, 32'h0, "write");
  endtask

  task automatic test_read();
    do_txn(8'h08, 1'b0, 32'h0, 4'hF, 0, 0, 1'b1, 32'hDEAD_BEEF, "read");
    do_txn(8'h0B, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0, "read_low_bits");
  endtask

  task automatic test_unmapped();
    do_txn(8'h40, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, "miss_read");
    do_txn(8'h40, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 1'b0, 32'h0, "miss_write");
  endtask

  task automatic test_wait_ready();
    do_txn(8'h0C, 1'b0, 32'h0, 4'hF, 5, 3, 1'b0, 32'h0, "wait_read");
    do_txn(8'h0C, 1'b1, 32'hCAFE_F00D, 4'b1010, 5, 3, 1'b0, 32'h0, "wait_write");
  endtask

  task automatic test_zero_strobe();
    do_txn(8'h00, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1'b0, 32'h0, "zero_strobe");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn(map[i], 1'($urandom), $urandom, 4'($urandom), 0, 0, 1'b0, 32'h0, "b2b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      do_txn(8'($urandom_range(0, 63)), 1'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 6), $urandom_range(0, 3), 1'b0, 32'h0, "random");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    register_ready = 4'h0;
    b.req_valid = 1'b1;
    b.address = 8'h0C;
    b.write = 1'b1;
    b.write_data = 32'h1111_2222;
    b.strobe = 4'hF;
    @(posedge clk); #1;
    b.req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({sel, wv} !== {4'b1000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid pre: sel %b wv %b want 1000 1", sel, wv);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({sel, wv, rv, b.resp_valid, b.req_ready} !== {4'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: sel %b wv %b rv %b v %b rdy %b want 0 0 0 0 1",
               sel, wv, rv, b.resp_valid, b.req_ready);
    end
    register_ready = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({b.resp_valid, b.req_ready, wv} !== 3'b010) begin
        n_err++;
        $display("FAIL reset_mid after: v %b rdy %b wv %b want 0 1 0",
                 b.resp_valid, b.req_ready, wv);
      end
    end
    do_txn(8'h0C, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, "after_reset");
  endtask

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(8'h0C, 1'b0, 32'h0, 4'hF, 1000, 1, 1'b0, 32'h0, "timeout");
  endtask
`endif

  initial begin
    b.req_valid = 1'b0;
    b.address = '0;
    b.write = 1'b0;
    b.write_data = '0;
    b.strobe = '0;
    b.resp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_unmapped();
    test_wait_ready();
    test_zero_strobe();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef RGGEN_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
